// File: rtl/mdu_pkg.sv
// Shared op encodings, latency defaults and op classification for the multiply/divide unit.
// MDU_MADD_EN adds the multiply-accumulate ops (MADD/MADDU/MSUB/MSUBU) to the multiply class.
package mdu_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam int MDU_MULT_CYCLES = 5;
    localparam int MDU_DIV_CYCLES  = 10;

    function automatic logic is_mul(input logic [3:0] op);
        case (op)
            MDU_MULT, MDU_MULTU: return 1'b1;
`ifdef MDU_MADD_EN
            MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath: computes the next {hi,lo} for the latched op and operands.
// Multiply-accumulate results exist only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_next,
    output logic [31:0] lo_next,
    output logic        div0
);

    logic signed [63:0] a_sx64;
    logic signed [63:0] b_sx64;
    logic        [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] b_safe;
    logic signed [32:0] a_sx33;
    logic signed [32:0] b_sx33;
    logic        [31:0] quot_s;
    logic        [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;

    assign a_sx64 = {{32{a[31]}}, a};
    assign b_sx64 = {{32{b[31]}}, b};
    assign prod_s = 64'(a_sx64 * b_sx64);
    assign prod_u = {32'd0, a} * {32'd0, b};

    // A zero divisor is replaced by 1 so the dividers never see it; the commit is suppressed by div0.
    assign div0   = is_div(op) && (b == 32'd0);
    assign b_safe = (b == 32'd0) ? 32'd1 : b;

    // 33-bit signed division makes 0x80000000 / -1 representable; truncation gives the wrapped quotient.
    assign a_sx33 = {a[31], a};
    assign b_sx33 = {b_safe[31], b_safe};
    assign quot_s = 32'(a_sx33 / b_sx33);
    assign rem_s  = 32'(a_sx33 % b_sx33);
    assign quot_u = a / b_safe;
    assign rem_u  = a % b_safe;

`ifdef MDU_MADD_EN
    logic [63:0] acc;
    assign acc = {hi, lo};
`endif

    always_comb begin
        hi_next = hi;
        lo_next = lo;
        case (op)
            MDU_MULT:  {hi_next, lo_next} = prod_s;
            MDU_MULTU: {hi_next, lo_next} = prod_u;
            MDU_DIV: begin
                lo_next = quot_s;
                hi_next = rem_s;
            end
            MDU_DIVU: begin
                lo_next = quot_u;
                hi_next = rem_u;
            end
`ifdef MDU_MADD_EN
            MDU_MADD:  {hi_next, lo_next} = acc + prod_s;
            MDU_MADDU: {hi_next, lo_next} = acc + prod_u;
            MDU_MSUB:  {hi_next, lo_next} = acc - prod_s;
            MDU_MSUBU: {hi_next, lo_next} = acc - prod_u;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// EX-stage multiply/divide unit owning HI/LO; fixed-latency ops report busy to the hazard unit.
// Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic          busy_reg;
    logic [CW-1:0] count_reg;
    logic [3:0]    op_reg;
    logic [31:0]   a_reg;
    logic [31:0]   b_reg;
    logic [31:0]   hi_reg;
    logic [31:0]   lo_reg;
    logic [31:0]   hi_next;
    logic [31:0]   lo_next;
    logic          div0;

    mdu_arith u_arith (
        .op      (op_reg),
        .a       (a_reg),
        .b       (b_reg),
        .hi      (hi_reg),
        .lo      (lo_reg),
        .hi_next (hi_next),
        .lo_next (lo_next),
        .div0    (div0)
    );

    // Any start sampled while busy, including the final busy edge, is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
            op_reg    <= MDU_NOP;
            a_reg     <= '0;
            b_reg     <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
        end else if (busy_reg) begin
            if (count_reg == CW'(1)) begin
                busy_reg  <= 1'b0;
                count_reg <= '0;
                if (!div0) begin
                    hi_reg <= hi_next;
                    lo_reg <= lo_next;
                end
            end else begin
                count_reg <= count_reg - CW'(1);
            end
        end else if (start) begin
            if (is_mul(op) || is_div(op)) begin
                busy_reg  <= 1'b1;
                count_reg <= is_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                op_reg    <= op;
                a_reg     <= rs_val;
                b_reg     <= rt_val;
            end else if (op == MDU_MTHI) begin
                hi_reg <= rs_val;
            end else if (op == MDU_MTLO) begin
                lo_reg <= rs_val;
            end
        end
    end

    assign busy = busy_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized scoreboard bench for mult_div_unit: stimulus pushes expected commits, a monitor
// pops and compares them whenever busy falls.
module tb_mult_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] hilo;
        int          cycles;
        logic [3:0]  op;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endfunction

    // Reference model: what a single op does to {hi,lo}, straight from the arithmetic rules.
    task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            output bit is_busy, output int cyc, output logic [63:0] res);
        longint          sa, sb, q, m;
        longint unsigned ua, ub;
        logic [63:0]     cur;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        cur = {model_hi, model_lo};
        is_busy = 1'b0;
        cyc = 0;
        res = cur;
        case (o)
            4'd1: begin is_busy = 1; cyc = MULT_N; res = sa * sb; end
            4'd2: begin is_busy = 1; cyc = MULT_N; res = ua * ub; end
            4'd3: begin
                is_busy = 1; cyc = DIV_N;
                if (b != 0) begin
                    q = sa / sb;
                    m = sa % sb;
                    res = {m[31:0], q[31:0]};
                end
            end
            4'd4: begin
                is_busy = 1; cyc = DIV_N;
                if (b != 0) res = {32'(ua % ub), 32'(ua / ub)};
            end
            4'd5: res = {a, model_lo};
            4'd6: res = {model_hi, a};
`ifdef MDU_MADD_EN
            4'd7:  begin is_busy = 1; cyc = MULT_N; res = cur + 64'(sa * sb); end
            4'd8:  begin is_busy = 1; cyc = MULT_N; res = cur + 64'(ua * ub); end
            4'd9:  begin is_busy = 1; cyc = MULT_N; res = cur - 64'(sa * sb); end
            4'd10: begin is_busy = 1; cyc = MULT_N; res = cur - 64'(ua * ub); end
`endif
            default: ;
        endcase
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (!busy && exp_q.size() == 0) break;
        end
        if (i == 60) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: busy=%b pending=%0d required idle", busy, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Issue one op; optionally keep start asserted with junk ops through every busy edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input bit inject);
        bit          is_busy;
        int          cyc;
        logic [63:0] res;
        model_op(o, a, b, is_busy, cyc, res);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        if (is_busy) exp_q.push_back('{res, cyc, o});
        @(negedge clk);
        start = 1'b0; op = 4'($urandom_range(0, 15)); rs_val = $urandom; rt_val = $urandom;
        if (!is_busy) begin
            check("idle_busy", {63'd0, busy}, 64'd0);
            check("idle_hilo", {hi, lo}, res);
            $display("op=%0d a=%h b=%h -> hi=%h lo=%h (no busy)", o, a, b, hi, lo);
            {model_hi, model_lo} = res;
        end else begin
            if (inject) begin
                for (int i = 0; i < cyc; i++) begin
                    start = 1'b1;
                    rs_val = $urandom; rt_val = $urandom;
                    if (i == 1)            begin op = 4'd6; rs_val = 32'h55; end
                    else if (i == cyc - 1) begin op = 4'd1; rs_val = 5; rt_val = 5; end
                    else                   op = 4'($urandom_range(0, 15));
                    @(negedge clk);
                end
                start = 1'b0;
            end
            wait_idle();
            {model_hi, model_lo} = res;
        end
    endtask

    // Monitor: measures each busy window and compares the commit when busy falls.
    bit prev_busy = 1'b0;
    int busy_cnt  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            prev_busy = 1'b0;
            busy_cnt  = 0;
        end else begin
            if (busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_commit: got hi=%h lo=%h required no commit", hi, lo);
                end else begin
                    e = exp_q.pop_front();
                    check("busy_cycles", 64'(busy_cnt), 64'(e.cycles));
                    check("commit_hilo", {hi, lo}, e.hilo);
                    $display("op=%0d busy=%0d cycles -> hi=%h lo=%h", e.op, busy_cnt, hi, lo);
                end
                busy_cnt = 0;
            end
            prev_busy = busy;
        end
    end

    initial begin
        logic [31:0] specials [4];
        specials[0] = 32'h0;
        specials[1] = 32'hFFFF_FFFF;
        specials[2] = 32'h8000_0000;
        specials[3] = 32'h7FFF_FFFF;

        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        #1 reset = 1'b1;

        issue(4'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        issue(4'd4, 32'd7, 32'd2, 1'b0);
        issue(4'd5, 32'h11, 32'd0, 1'b0);
        issue(4'd6, 32'h22, 32'd0, 1'b0);
        issue(4'd3, 32'h1234_5678, 32'd0, 1'b0);
        issue(4'd1, 32'd3, 32'd4, 1'b1);
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(4'd5, 32'd0, 32'd0, 1'b0);
        issue(4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
        issue(4'd8, 32'd1, 32'd1, 1'b0);

        // Abort a MULT in flight; HI/LO are made nonzero first so the clear is observable.
        issue(4'd5, 32'hAAAA_0001, 32'd0, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 4'd1; rs_val = 32'd6; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        model_hi = 32'd0;
        model_lo = 32'd0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            check("post_abort_idle", {31'd0, busy, hi, lo}, 64'd0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 2) == 0) b = b & 32'h0000_00FF;
            issue(4'($urandom_range(0, 15)), a, b, bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
